pcileech_bar_poll_seq: RTL and testbench

Parametrised BAR read/write responder that returns a programmable sequence of values from each of NUM_CH polled offsets. Each read of a poll offset returns the next entry and advances that channel's index. It sits behind the pcileech BAR TLP dispatcher, in the same slot as a fixed BAR implementation. Sequence contents, length and end-of-sequence mode are loadable at runtime through BAR writes, so a new polling profile needs no resynthesis.

---
 rtl/pcileech_bar_poll_pkg.sv | 48 ++++
 rtl/pcileech_bar_poll_chan.sv | 77 +++++++
 rtl/pcileech_bar_poll_seq.sv | 141 ++++++++++++++
 tb/tb_pcileech_bar_poll_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_bar_poll_pkg.sv
// Shared types, control-register layout and the BAR window decoder for the
// sequenced poll responder.
package pcileech_bar_poll_pkg;

  localparam int LAST_LSB = 0;
  localparam int MODE_BIT = 8;
  localparam int IDX_LSB  = 16;
  localparam int RST_BIT  = 31;

  typedef enum logic {MODE_WRAP = 1'b0, MODE_HOLD = 1'b1} poll_mode_e;

  typedef enum logic [1:0] {REGION_NONE, REGION_POLL, REGION_CTL, REGION_SEQ} region_e;

  typedef struct packed {
    region_e    region;
    logic [3:0] chan;
    logic [7:0] ent;
  } poll_dec_t;

  function automatic logic windows_overlap(input logic [31:0] a_lo, a_hi, b_lo, b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

  // Entry indices that fall past the sequence depth decode as unmapped.
  function automatic poll_dec_t poll_decode(input logic [31:0] off, num_ch, seq_depth, idx_w,
                                            poll_base, ctl_base, seq_base);
    poll_dec_t   dec;
    logic [31:0] word;
    dec.region = REGION_NONE;
    dec.chan   = '0;
    dec.ent    = '0;
    word       = '0;
    if (off >= poll_base && off < poll_base + (num_ch << 2)) begin
      dec.region = REGION_POLL;
      dec.chan   = 4'((off - poll_base) >> 2);
    end else if (off >= ctl_base && off < ctl_base + (num_ch << 2)) begin
      dec.region = REGION_CTL;
      dec.chan   = 4'((off - ctl_base) >> 2);
    end else if (off >= seq_base && off < seq_base + ((num_ch << idx_w) << 2)) begin
      word     = (off - seq_base) >> 2;
      dec.chan = 4'(word >> idx_w);
      dec.ent  = 8'(word & ((32'd1 << idx_w) - 32'd1));
      if (32'(dec.ent) < seq_depth) dec.region = REGION_SEQ;
    end
    return dec;
  endfunction

endpackage

// File: rtl/pcileech_bar_poll_chan.sv
// One polled channel: entry storage plus the idx/last/mode sequencing state.
module pcileech_bar_poll_chan
  import pcileech_bar_poll_pkg::*;
#(
  parameter int SEQ_DEPTH = 35,
  parameter int IDX_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll,
  input  logic        last_we,
  input  logic [7:0]  last_wdata,
  input  logic        mode_we,
  input  logic        mode_wdata,
  input  logic        idx_clr,
  input  logic        ent_we,
  input  logic [7:0]  ent_widx,
  input  logic [3:0]  ent_be,
  input  logic [31:0] ent_wdata,
  input  logic [7:0]  ent_ridx,
  output logic [31:0] cur_entry,
  output logic [31:0] rd_entry,
  output logic [31:0] status
);

  logic [31:0]      entry_reg [SEQ_DEPTH];
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] last_reg, last_clamped;
  poll_mode_e       mode_reg;

  assign last_clamped = (32'(last_wdata) > 32'(SEQ_DEPTH - 1)) ? IDX_W'(SEQ_DEPTH - 1)
                                                                 : last_wdata[IDX_W-1:0];

  always_comb begin
    idx_next = idx_reg + IDX_W'(1);
    if (idx_reg == last_reg) idx_next = (mode_reg == MODE_HOLD) ? last_reg : '0;
  end

  // An idx clear from a control write takes priority over a same-cycle poll advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SEQ_DEPTH; i++) entry_reg[i] <= '0;
      idx_reg  <= '0;
      last_reg <= IDX_W'(SEQ_DEPTH - 1);
      mode_reg <= MODE_WRAP;
    end else begin
      for (int i = 0; i < SEQ_DEPTH; i++) begin
        if (ent_we && ent_widx == 8'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (ent_be[b]) entry_reg[i][8*b +: 8] <= ent_wdata[8*b +: 8];
          end
        end
      end
      if (last_we) last_reg <= last_clamped;
      if (mode_we) mode_reg <= poll_mode_e'(mode_wdata);
      if (idx_clr)   idx_reg <= '0;
      else if (poll) idx_reg <= idx_next;
    end
  end

  assign cur_entry = entry_reg[idx_reg];

  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      if (ent_ridx == 8'(i)) rd_entry = entry_reg[i];
    end
  end

  always_comb begin
    status                  = '0;
    status[LAST_LSB +: 8]   = 8'(last_reg);
    status[MODE_BIT]        = mode_reg;
    status[IDX_LSB +: 8]    = 8'(idx_reg);
  end

endmodule

// File: rtl/pcileech_bar_poll_seq.sv
// BAR responder returning a runtime-programmable value sequence per polled offset.
// Two stages: input register, then decode/lookup/update with a registered response.
module pcileech_bar_poll_seq
  import pcileech_bar_poll_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                SEQ_DEPTH = 35,
  parameter int                ADDR_W    = 20,
  parameter int                CTX_W     = 88,
  parameter logic [ADDR_W-1:0] POLL_BASE = 'h00000,
  parameter logic [ADDR_W-1:0] CTL_BASE  = 'h00100,
  parameter logic [ADDR_W-1:0] SEQ_BASE  = 'h01000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wr_addr,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  input  logic [CTX_W-1:0] rd_req_ctx,
  input  logic [31:0]      rd_req_addr,
  input  logic             rd_req_valid,
  input  logic [31:0]      base_address_register,
  output logic [CTX_W-1:0] rd_rsp_ctx,
  output logic [31:0]      rd_rsp_data,
  output logic             rd_rsp_valid
);

  localparam int          IDX_W    = $clog2(SEQ_DEPTH);
  localparam logic [31:0] POLL_END = 32'(POLL_BASE) + 32'(4 * NUM_CH);
  localparam logic [31:0] CTL_END  = 32'(CTL_BASE) + 32'(4 * NUM_CH);
  localparam logic [31:0] SEQ_END  = 32'(SEQ_BASE) + 32'((NUM_CH << IDX_W) * 4);

  if (SEQ_DEPTH < 2 || SEQ_DEPTH > 256) begin : g_bad_depth
    $error("pcileech_bar_poll_seq: SEQ_DEPTH must be in 2..256");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_chan
    $error("pcileech_bar_poll_seq: NUM_CH must be in 1..16");
  end
  if (windows_overlap(32'(POLL_BASE), POLL_END, 32'(CTL_BASE), CTL_END) ||
      windows_overlap(32'(POLL_BASE), POLL_END, 32'(SEQ_BASE), SEQ_END) ||
      windows_overlap(32'(CTL_BASE), CTL_END, 32'(SEQ_BASE), SEQ_END)) begin : g_bad_windows
    $error("pcileech_bar_poll_seq: poll, control and entry windows overlap");
  end

  logic             rd_valid_reg, wr_valid_reg;
  logic [31:0]      rd_addr_reg, wr_addr_reg, wr_data_reg;
  logic [CTX_W-1:0] rd_ctx_reg;
  logic [3:0]       wr_be_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      rd_ctx_reg   <= '0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_be_reg    <= '0;
      wr_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_req_valid;
      rd_addr_reg  <= rd_req_addr;
      rd_ctx_reg   <= rd_req_ctx;
      wr_valid_reg <= wr_valid;
      wr_addr_reg  <= wr_addr;
      wr_be_reg    <= wr_be;
      wr_data_reg  <= wr_data;
    end
  end

  logic [31:0]       bar_base;
  logic [ADDR_W-1:0] rd_local, wr_local;
  poll_dec_t         rd_dec, wr_dec;

  assign bar_base = base_address_register & 32'hFFFF_FFF0;
  assign rd_local = ADDR_W'(rd_addr_reg - bar_base);
  assign wr_local = ADDR_W'(wr_addr_reg - bar_base);
  assign rd_dec   = poll_decode(32'(rd_local), 32'(NUM_CH), 32'(SEQ_DEPTH), 32'(IDX_W),
                                32'(POLL_BASE), 32'(CTL_BASE), 32'(SEQ_BASE));
  assign wr_dec   = poll_decode(32'(wr_local), 32'(NUM_CH), 32'(SEQ_DEPTH), 32'(IDX_W),
                                32'(POLL_BASE), 32'(CTL_BASE), 32'(SEQ_BASE));

  logic [31:0] cur_entry [NUM_CH];
  logic [31:0] rd_entry  [NUM_CH];
  logic [31:0] status    [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic ctl_hit, seq_hit;
    assign ctl_hit = wr_valid_reg && (wr_dec.region == REGION_CTL) && (wr_dec.chan == 4'(gi));
    assign seq_hit = wr_valid_reg && (wr_dec.region == REGION_SEQ) && (wr_dec.chan == 4'(gi));

    // Any byte-0 write also restarts the sequence, as does bit 31 on lane 3.
    pcileech_bar_poll_chan #(.SEQ_DEPTH(SEQ_DEPTH), .IDX_W(IDX_W)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .poll       (rd_valid_reg && (rd_dec.region == REGION_POLL) && (rd_dec.chan == 4'(gi))),
      .last_we    (ctl_hit && wr_be_reg[0]),
      .last_wdata (wr_data_reg[LAST_LSB +: 8]),
      .mode_we    (ctl_hit && wr_be_reg[1]),
      .mode_wdata (wr_data_reg[MODE_BIT]),
      .idx_clr    (ctl_hit && (wr_be_reg[0] || (wr_be_reg[3] && wr_data_reg[RST_BIT]))),
      .ent_we     (seq_hit),
      .ent_widx   (wr_dec.ent),
      .ent_be     (wr_be_reg),
      .ent_wdata  (wr_data_reg),
      .ent_ridx   (rd_dec.ent),
      .cur_entry  (cur_entry[gi]),
      .rd_entry   (rd_entry[gi]),
      .status     (status[gi])
    );
  end

  logic [31:0] rsp_data_next;

  always_comb begin
    rsp_data_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_dec.chan == 4'(c)) begin
        case (rd_dec.region)
          REGION_POLL: rsp_data_next = cur_entry[c];
          REGION_CTL:  rsp_data_next = status[c];
          REGION_SEQ:  rsp_data_next = rd_entry[c];
          default:     rsp_data_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_ctx   <= '0;
    end else begin
      rd_rsp_valid <= rd_valid_reg;
      rd_rsp_data  <= rd_valid_reg ? rsp_data_next : '0;
      rd_rsp_ctx   <= rd_ctx_reg;
    end
  end

endmodule

// File: tb/tb_pcileech_bar_poll_seq.sv
// Directed and randomized bench for pcileech_bar_poll_seq against a per-channel
// sequence model; every response is matched to its request two cycles later.
module tb_pcileech_bar_poll_seq;

  localparam int          NCH      = 4;
  localparam int          DEPTH    = 35;
  localparam int          IDXW     = 6;
  localparam int          CTXW     = 88;
  localparam logic [31:0] BAR      = 32'hF7C0_000C;
  localparam logic [31:0] BAR_BASE = 32'hF7C0_0000;

  logic            clk, rst;
  logic [31:0]     wr_addr, wr_data, rd_req_addr, base_address_register, rd_rsp_data;
  logic [3:0]      wr_be;
  logic            wr_valid, rd_req_valid, rd_rsp_valid;
  logic [CTXW-1:0] rd_req_ctx, rd_rsp_ctx;

  pcileech_bar_poll_seq #(
    .NUM_CH(NCH), .SEQ_DEPTH(DEPTH), .ADDR_W(20), .CTX_W(CTXW),
    .POLL_BASE(20'h00000), .CTL_BASE(20'h00100), .SEQ_BASE(20'h01000)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
    .base_address_register(base_address_register),
    .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sequence state per channel.
  logic [31:0] m_ent [NCH][DEPTH];
  int          m_idx [NCH];
  int          m_last[NCH];
  bit          m_mode[NCH];

  typedef struct {
    int              due;
    logic [CTXW-1:0] ctx;
    logic [31:0]     data;
    string           tag;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] poll_off(input int c);
    return 32'(4 * c);
  endfunction
  function automatic logic [31:0] ctl_off(input int c);
    return 32'h100 + 32'(4 * c);
  endfunction
  function automatic logic [31:0] seq_off(input int c, input int i);
    return 32'h1000 + 32'(4 * ((c << IDXW) + i));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_idx[c] = 0; m_last[c] = DEPTH - 1; m_mode[c] = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_ent[c][i] = '0;
    end
  endtask

  // kind: 0 unmapped, 1 poll, 2 control, 3 entry
  task automatic model_decode(input logic [31:0] off, output int kind, output int c, output int i);
    int w;
    kind = 0; c = 0; i = 0; w = 0;
    if (off < 32'(4 * NCH)) begin
      kind = 1; c = int'(off / 4);
    end else if (off >= 32'h100 && off < 32'h100 + 32'(4 * NCH)) begin
      kind = 2; c = int'((off - 32'h100) / 4);
    end else if (off >= 32'h1000 && off < 32'h1000 + 32'(4 * NCH * (1 << IDXW))) begin
      w = int'((off - 32'h1000) / 4);
      c = w / (1 << IDXW);
      i = w % (1 << IDXW);
      if (i < DEPTH) kind = 3;
    end
  endtask

  task automatic model_read(input logic [31:0] off, output logic [31:0] data, output int pc);
    int kind, c, i;
    model_decode(off, kind, c, i);
    data = '0; pc = -1;
    case (kind)
      1: begin data = m_ent[c][m_idx[c]]; pc = c; end
      2: data = {8'h00, 8'(m_idx[c]), 7'h00, m_mode[c], 8'(m_last[c])};
      3: data = m_ent[c][i];
      default: data = '0;
    endcase
  endtask

  task automatic model_advance(input int c);
    if (m_idx[c] == m_last[c]) m_idx[c] = m_mode[c] ? m_last[c] : 0;
    else m_idx[c] = m_idx[c] + 1;
  endtask

  task automatic model_write(input logic [31:0] off, input logic [3:0] be, input logic [31:0] wd);
    int kind, c, i;
    model_decode(off, kind, c, i);
    if (kind == 2) begin
      if (be[0]) begin
        m_last[c] = (int'(wd[7:0]) > DEPTH - 1) ? DEPTH - 1 : int'(wd[7:0]);
        m_idx[c]  = 0;
      end
      if (be[1]) m_mode[c] = wd[8];
      if (be[3] && wd[31]) m_idx[c] = 0;
    end else if (kind == 3) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_ent[c][i][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  // One bus cycle: optional read and optional write presented together.
  task automatic xact(input bit rv, input logic [31:0] roff, input bit wv, input logic [31:0] woff,
                      input logic [3:0] be, input logic [31:0] wd, input string tag);
    exp_t        e;
    int          pc;
    logic [31:0] rdata;
    @(negedge clk);
    rd_req_valid = rv;
    rd_req_addr  = BAR_BASE + roff;
    rd_req_ctx   = CTXW'({$urandom(), $urandom(), $urandom()});
    wr_valid     = wv;
    wr_addr      = BAR_BASE + woff;
    wr_be        = be;
    wr_data      = wd;
    pc = -1;
    rdata = '0;
    if (rv) begin
      model_read(roff, rdata, pc);
      e.due = cyc + 2; e.ctx = rd_req_ctx; e.data = rdata; e.tag = tag;
      exp_q.push_back(e);
    end
    if (pc >= 0) model_advance(pc);
    if (wv) model_write(woff, be, wd);
  endtask

  task automatic rd(input logic [31:0] off, input string tag);
    xact(1'b1, off, 1'b0, 32'h0, 4'h0, 32'h0, tag);
  endtask
  task automatic wr(input logic [31:0] off, input logic [3:0] be, input logic [31:0] wd);
    xact(1'b0, 32'h0, 1'b1, off, be, wd, "");
  endtask
  task automatic idle();
    xact(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, "");
  endtask

  // Response checker: each cycle either the oldest expected response is due, or the bus is quiet.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (rd_rsp_valid === 1'b1) else begin
        n_bad++; $error("FAIL %s valid: got %b want 1", e.tag, rd_rsp_valid);
      end
      n_cmp++;
      assert (rd_rsp_data === e.data) else begin
        n_bad++; $error("FAIL %s data: got %08h want %08h", e.tag, rd_rsp_data, e.data);
      end
      n_cmp++;
      assert (rd_rsp_ctx === e.ctx) else begin
        n_bad++; $error("FAIL %s ctx: got %h want %h", e.tag, rd_rsp_ctx, e.ctx);
      end
      $display("rsp %-10s cyc=%0d data=%08h ctx=%h", e.tag, cyc, rd_rsp_data, rd_rsp_ctx);
    end else begin
      n_cmp++;
      assert (rd_rsp_valid === 1'b0 && rd_rsp_data === 32'h0) else begin
        n_bad++; $error("FAIL idle_bus: got valid=%b data=%08h want valid=0 data=0", rd_rsp_valid, rd_rsp_data);
      end
    end
  end

  initial begin
    bit          rv, wv;
    int          c, i;
    logic [31:0] roff, woff, wd;
    logic [3:0]  be;
    rst = 1'b1;
    wr_addr = '0; wr_be = '0; wr_data = '0; wr_valid = 1'b0;
    rd_req_ctx = '0; rd_req_addr = '0; rd_req_valid = 1'b0;
    base_address_register = BAR;
    #1 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    assert (rd_rsp_ctx === '0) else begin
      n_bad++; $error("FAIL reset_ctx: got %h want 0", rd_rsp_ctx);
    end
    rst = 1'b1;

    // Reset state of control registers.
    rd(ctl_off(0), "ctl0_rst");
    rd(ctl_off(3), "ctl3_rst");

    // Wrap mode sequence.
    for (int k = 0; k < 5; k++) wr(seq_off(0, k), 4'hF, 32'hA0 + 32'(k));
    wr(ctl_off(0), 4'b0011, 32'h0000_0004);
    for (int k = 0; k < 7; k++) rd(poll_off(0), "wrap");

    // Hold mode sequence.
    wr(ctl_off(0), 4'b0011, 32'h0000_0104);
    for (int k = 0; k < 7; k++) rd(poll_off(0), "hold");
    rd(ctl_off(0), "ctl_hold");

    // Interleaved channels; entry-window reads must not move idx.
    for (int k = 0; k < 3; k++) wr(seq_off(1, k), 4'hF, 32'hB0 + 32'(k));
    wr(ctl_off(1), 4'b0001, 32'h0000_0002);
    wr(ctl_off(0), 4'b0011, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      rd(poll_off(0), "ilv_ch0");
      rd(poll_off(1), "ilv_ch1");
    end
    rd(seq_off(0, 1), "seq_rd0");
    rd(seq_off(1, 2), "seq_rd1");
    rd(poll_off(0), "ilv_ch0");
    rd(poll_off(1), "ilv_ch1");

    // Index reset racing a poll, then clamped last.
    wr(ctl_off(0), 4'b0011, 32'h0000_0004);
    for (int k = 0; k < 3; k++) rd(poll_off(0), "pre_clr");
    xact(1'b1, poll_off(0), 1'b1, ctl_off(0), 4'b1000, 32'h8000_0000, "poll_clr");
    rd(poll_off(0), "after_clr");
    wr(ctl_off(0), 4'b0001, 32'd300);
    rd(ctl_off(0), "clamp");

    // Read-before-write and byte lanes in the entry window.
    xact(1'b1, seq_off(2, 5), 1'b1, seq_off(2, 5), 4'hF, 32'hDEAD_BEEF, "rbw_old");
    rd(seq_off(2, 5), "rbw_new");
    wr(seq_off(2, 5), 4'b0100, 32'h0055_0000);
    rd(seq_off(2, 5), "lane2");

    // Unmapped and out-of-depth accesses.
    wr(32'h800, 4'hF, 32'h1234_5678);
    rd(32'h800, "unmapped");
    wr(seq_off(0, 40), 4'hF, 32'h1111_2222);
    rd(seq_off(0, 40), "past_depth");

    // Randomized traffic over preloaded channels.
    for (int cc = 0; cc < NCH; cc++)
      for (int ii = 0; ii < DEPTH; ii++) wr(seq_off(cc, ii), 4'hF, $urandom());
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(9) < 7);
      c = int'($urandom_range(NCH - 1));
      i = int'($urandom_range(DEPTH - 1));
      case ($urandom_range(3))
        0, 1:    roff = poll_off(c);
        2:       roff = ctl_off(c);
        default: roff = seq_off(c, i);
      endcase
      wv = ($urandom_range(9) < 3);
      c = int'($urandom_range(NCH - 1));
      wd = $urandom();
      if ($urandom_range(1) == 1) begin
        woff = ctl_off(c);
        wd[7:0] = 8'($urandom_range(40));
      end else begin
        woff = seq_off(c, int'($urandom_range(DEPTH - 1)));
      end
      be = 4'($urandom_range(15));
      xact(rv, roff, wv, woff, be, wd, "rand");
    end

    // Reset with two reads in flight: neither may respond.
    rd(poll_off(0), "inflight");
    void'(exp_q.pop_back());
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_addr = BAR_BASE + poll_off(1); wr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    rd(poll_off(0), "post_rst");
    rd(ctl_off(1), "ctl_post");
    idle();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++; $error("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
